// File: rtl/eight_to_thirty_two.sv
// Byte-to-word deserializer: gathers four bytes (LSB first) after a start marker and emits a 32-bit word.
// Optional inter-byte idle timeout is enabled by defining EIGHT_TO_THIRTY_TWO_TIMEOUT_EN.
module eight_to_thirty_two #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        div_8_clk,
    input  logic        rst_n,
    input  logic        rx_start,
    input  logic        byte_valid,
    input  logic [7:0]  data_in,
    output logic [31:0] data_out,
    output logic        word_valid,
    output logic        busy,
    output logic        frame_err,
    output logic [7:0]  words_rx
);

    // State name is the index of the next byte expected
    typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

    state_t      state_q, state_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] data_out_q, data_out_d;
    logic        word_valid_q, word_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  words_rx_q, words_rx_d;

`ifdef EIGHT_TO_THIRTY_TWO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        data_out_d   = data_out_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        words_rx_d   = words_rx_q;

        if (byte_valid && rx_start) begin
            // A start byte always begins a fresh word; mid-word it is a resync
            if (state_q != IDLE) begin
                frame_err_d = 1'b1;
            end
            buf_d   = {16'h0000, data_in};
            state_d = B1;
        end else if (byte_valid) begin
            case (state_q)
                B1: begin
                    buf_d[15:8] = data_in;
                    state_d     = B2;
                end
                B2: begin
                    buf_d[23:16] = data_in;
                    state_d      = B3;
                end
                B3: begin
                    data_out_d   = {data_in, buf_q};
                    word_valid_d = 1'b1;
                    words_rx_d   = words_rx_q + 8'd1;
                    state_d      = IDLE;
                end
                default: ;
            endcase
        end

`ifdef EIGHT_TO_THIRTY_TWO_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
        if (state_d == IDLE || byte_valid) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == CNT_LAST) begin
            // Last tolerated idle cycle: abandon the partial word
            state_d     = IDLE;
            buf_d       = '0;
            frame_err_d = 1'b1;
            idle_cnt_d  = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge div_8_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            data_out_q   <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            words_rx_q   <= '0;
`ifdef EIGHT_TO_THIRTY_TWO_TIMEOUT_EN
            idle_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            data_out_q   <= data_out_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            words_rx_q   <= words_rx_d;
`ifdef EIGHT_TO_THIRTY_TWO_TIMEOUT_EN
            idle_cnt_q   <= idle_cnt_d;
`endif
        end
    end

    assign data_out   = data_out_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign words_rx   = words_rx_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_eight_to_thirty_two.sv
// Self-checking bench for eight_to_thirty_two: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_eight_to_thirty_two;

    localparam int T = 4;

    logic        clk;
    logic        rst_n;
    logic        rx_start;
    logic        byte_valid;
    logic [7:0]  data_in;
    logic [31:0] data_out;
    logic        word_valid;
    logic        busy;
    logic        frame_err;
    logic [7:0]  words_rx;

    int errors = 0;
    int checks = 0;

    eight_to_thirty_two #(.TIMEOUT_CYCLES(T)) dut (
        .div_8_clk (clk),
        .rst_n     (rst_n),
        .rx_start  (rx_start),
        .byte_valid(byte_valid),
        .data_in   (data_in),
        .data_out  (data_out),
        .word_valid(word_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .words_rx  (words_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: bytes of the word in progress kept in a queue
    logic [7:0]  q[$];
    int          idle_run;
    logic [31:0] exp_data;
    logic        exp_wv;
    logic        exp_fe;
    logic [7:0]  exp_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            idle_run = 0;
            exp_data = 32'h0;
            exp_wv   = 1'b0;
            exp_fe   = 1'b0;
            exp_cnt  = 8'h0;
        end else begin
            exp_wv = 1'b0;
            exp_fe = 1'b0;
            if (byte_valid) begin
                idle_run = 0;
                if (rx_start) begin
                    if (q.size() != 0) exp_fe = 1'b1;
                    q.delete();
                    q.push_back(data_in);
                end else if (q.size() != 0) begin
                    q.push_back(data_in);
                    if (q.size() == 4) begin
                        exp_data = {q[3], q[2], q[1], q[0]};
                        exp_wv   = 1'b1;
                        exp_cnt  = exp_cnt + 8'd1;
                        q.delete();
                    end
                end
            end else if (q.size() != 0) begin
`ifdef EIGHT_TO_THIRTY_TWO_TIMEOUT_EN
                idle_run++;
                if (idle_run == T) begin
                    q.delete();
                    idle_run = 0;
                    exp_fe   = 1'b1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("data_out", data_out, exp_data);
        check("word_valid", {31'b0, word_valid}, {31'b0, exp_wv});
        check("frame_err", {31'b0, frame_err}, {31'b0, exp_fe});
        check("words_rx", {24'b0, words_rx}, {24'b0, exp_cnt});
        check("busy", {31'b0, busy}, {31'b0, q.size() != 0});
    end

    task automatic send(input logic s, input logic [7:0] b);
        @(posedge clk);
        #2;
        rx_start   = s;
        byte_valid = 1'b1;
        data_in    = b;
    endtask

    task automatic gap();
        @(posedge clk);
        #2;
        rx_start   = 1'b0;
        byte_valid = 1'b0;
        data_in    = $urandom_range(0, 255);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        rx_start   = 1'b0;
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_word_valid", {31'b0, word_valid}, 32'h0);
        check("rst_frame_err", {31'b0, frame_err}, 32'h0);
        check("rst_words_rx", {24'b0, words_rx}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_start   = 1'b0;
        byte_valid = 1'b0;
        data_in    = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Contiguous word
        send(1, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
        gap();
        check("contig_data", data_out, 32'h44332211);
        check("contig_wv", {31'b0, word_valid}, 32'h1);
        check("contig_cnt", {24'b0, words_rx}, 32'h1);
        gap();
        check("contig_wv_drop", {31'b0, word_valid}, 32'h0);

        // Asynchronous reset mid-word, then a clean word
        send(1, 8'h5A); send(0, 8'h6B);
        do_reset();
        send(1, 8'hEF); send(0, 8'hBE); send(0, 8'hAD); send(0, 8'hDE);
        gap();
        check("post_rst_data", data_out, 32'hDEADBEEF);

        // Gapped word followed by back-to-back word
        do_reset();
        send(1, 8'hAA); gap(); gap(); gap();
        send(0, 8'hBB); send(0, 8'hCC); send(0, 8'hDD);
        send(1, 8'h01);
        check("gap_data", data_out, 32'hDDCCBBAA);
        check("gap_wv", {31'b0, word_valid}, 32'h1);
        send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
        gap();
        check("b2b_data", data_out, 32'h04030201);
        check("b2b_cnt", {24'b0, words_rx}, 32'h2);

        // Resync
        do_reset();
        send(1, 8'h10); send(0, 8'h20); send(1, 8'h55); send(0, 8'h66);
        check("resync_fe", {31'b0, frame_err}, 32'h1);
        check("resync_no_wv", {31'b0, word_valid}, 32'h0);
        send(0, 8'h77); send(0, 8'h88);
        gap();
        check("resync_data", data_out, 32'h88776655);
        check("resync_cnt", {24'b0, words_rx}, 32'h1);

        // Idle timeout (or its absence)
        do_reset();
        send(1, 8'h01);
        repeat (T) gap();
        check("to_fe_early", {31'b0, frame_err}, 32'h0);
        check("to_busy_early", {31'b0, busy}, 32'h1);
        gap();
`ifdef EIGHT_TO_THIRTY_TWO_TIMEOUT_EN
        check("to_fe", {31'b0, frame_err}, 32'h1);
        check("to_busy", {31'b0, busy}, 32'h0);
`else
        check("to_fe", {31'b0, frame_err}, 32'h0);
        check("to_busy", {31'b0, busy}, 32'h1);
`endif
        send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
        gap();
`ifdef EIGHT_TO_THIRTY_TWO_TIMEOUT_EN
        check("to_no_wv", {31'b0, word_valid}, 32'h0);
        check("to_data", data_out, 32'h0);
`else
        check("to_wv", {31'b0, word_valid}, 32'h1);
        check("to_data", data_out, 32'h04030201);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                repeat (T + 2) gap();
            end else if ($urandom_range(0, 3) == 0) begin
                gap();
            end else begin
                send($urandom_range(0, 6) == 0, 8'($urandom_range(0, 255)));
            end
        end

        // Counter wrap over 256 words with stray idle bytes in between
        do_reset();
        for (int w = 0; w < 256; w++) begin
            send(1, 8'($urandom_range(0, 255)));
            for (int k = 0; k < 3; k++) begin
                repeat ($urandom_range(0, T - 2)) gap();
                send(0, 8'($urandom_range(0, 255)));
            end
            if ($urandom_range(0, 3) == 0) send(0, 8'($urandom_range(0, 255)));
        end
        gap();
        send(0, 8'h99);
        gap();
        check("wrap_cnt", {24'b0, words_rx}, 32'h0);
        gap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
